id_ex_stage: RTL and testbench

- ID/EX pipeline register and EX-stage operand selection for the 5-stage RV32I core.
- Captures decoded operands and control from decode, then forwards results from MEM and WB.
- Drives SrcA/SrcB/ALUControl straight into the ALU.
- Detects load-use hazards and inserts a bubble into EX on its own. Decode-side stall is driven externally from LoadUse_o.

---
 rtl/id_ex_stage.sv | 87 ++++++++
 tb/tb_id_ex_stage.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with MEM/WB forwarding, ALU operand select and load-use bubble insertion.
module id_ex_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic                      valid_i,
  input  logic [DATA_WIDTH-1:0]     RD1_i,
  input  logic [DATA_WIDTH-1:0]     RD2_i,
  input  logic [DATA_WIDTH-1:0]     ImmExt_i,
  input  logic [DATA_WIDTH-1:0]     PC_i,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2_i,
  input  logic [REG_ADDR_WIDTH-1:0] Rd_i,
  input  logic [2:0]                ALUControl_i,
  input  logic                      ALUSrcA_i,
  input  logic                      ALUSrcB_i,
  input  logic                      RegWrite_i,
  input  logic                      MemWrite_i,
  input  logic [1:0]                ResultSrc_i,
  input  logic [DATA_WIDTH-1:0]     ALUResultM_i,
  input  logic [REG_ADDR_WIDTH-1:0] RdM_i,
  input  logic                      RegWriteM_i,
  input  logic [DATA_WIDTH-1:0]     ResultW_i,
  input  logic [REG_ADDR_WIDTH-1:0] RdW_i,
  input  logic                      RegWriteW_i,
  output logic [DATA_WIDTH-1:0]     SrcA_o,
  output logic [DATA_WIDTH-1:0]     SrcB_o,
  output logic [2:0]                ALUControl_o,
  output logic [DATA_WIDTH-1:0]     WriteData_o,
  output logic [DATA_WIDTH-1:0]     PCE_o,
  output logic [REG_ADDR_WIDTH-1:0] RdE_o,
  output logic                      RegWriteE_o,
  output logic                      MemWriteE_o,
  output logic [1:0]                ResultSrcE_o,
  output logic                      ValidE_o,
  output logic                      LoadUse_o
);
  typedef struct packed {
    logic                      valid;
    logic [DATA_WIDTH-1:0]     rd1;
    logic [DATA_WIDTH-1:0]     rd2;
    logic [DATA_WIDTH-1:0]     imm;
    logic [DATA_WIDTH-1:0]     pc;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [2:0]                alu_ctrl;
    logic                      src_a_sel;
    logic                      src_b_sel;
    logic                      reg_write;
    logic                      mem_write;
    logic [1:0]                result_src;
  } ex_t;
  ex_t ex_q, ex_d, cap;
  logic [DATA_WIDTH-1:0] fwd_a, fwd_b;
  always_comb begin
    cap = '{valid: 1'b1, rd1: RD1_i, rd2: RD2_i, imm: ImmExt_i, pc: PC_i,
            rs1: Rs1_i, rs2: Rs2_i, rd: Rd_i, alu_ctrl: ALUControl_i,
            src_a_sel: ALUSrcA_i, src_b_sel: ALUSrcB_i, reg_write: RegWrite_i,
            mem_write: MemWrite_i, result_src: ResultSrc_i};
    ex_d = (rst_i || flush_i) ? '0 : stall_i ? ex_q : (LoadUse_o || !valid_i) ? '0 : cap;
  end
  always_ff @(posedge clk_i) ex_q <= ex_d;
  // x0 is hardwired zero, so a write to it must never be forwarded
  always_comb begin
    fwd_a = (RegWriteM_i && RdM_i == ex_q.rs1 && RdM_i != '0) ? ALUResultM_i :
            (RegWriteW_i && RdW_i == ex_q.rs1 && RdW_i != '0) ? ResultW_i : ex_q.rd1;
    fwd_b = (RegWriteM_i && RdM_i == ex_q.rs2 && RdM_i != '0) ? ALUResultM_i :
            (RegWriteW_i && RdW_i == ex_q.rs2 && RdW_i != '0) ? ResultW_i : ex_q.rd2;
  end
  assign LoadUse_o    = ex_q.valid && ex_q.result_src == 2'b01 && ex_q.rd != '0 && valid_i &&
                        (Rs1_i == ex_q.rd || Rs2_i == ex_q.rd);
  assign SrcA_o       = ex_q.src_a_sel ? ex_q.pc : fwd_a;
  assign SrcB_o       = ex_q.src_b_sel ? ex_q.imm : fwd_b;
  assign WriteData_o  = fwd_b;
  assign ALUControl_o = ex_q.alu_ctrl;
  assign PCE_o        = ex_q.pc;
  assign RdE_o        = ex_q.rd;
  assign RegWriteE_o  = ex_q.reg_write;
  assign MemWriteE_o  = ex_q.mem_write;
  assign ResultSrcE_o = ex_q.result_src;
  assign ValidE_o     = ex_q.valid;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed plus randomized checks of id_ex_stage against a behavioural model.
module tb_id_ex_stage;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst, stall, flush, valid, alu_sa, alu_sb, rw, mw, rwm, rww, lu;
  logic [31:0] rd1, rd2, imm, pc, alu_m, res_w, srca, srcb, wdata, pce;
  logic [4:0] rs1, rs2, rd, rdm, rdw, rde;
  logic [2:0] aluc, aluce;
  logic [1:0] rsrc, rsrce;
  logic rwe, mwe, vale;
  int total = 0, bad = 0;
  id_ex_stage dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .valid_i(valid),
    .RD1_i(rd1), .RD2_i(rd2), .ImmExt_i(imm), .PC_i(pc), .Rs1_i(rs1), .Rs2_i(rs2), .Rd_i(rd),
    .ALUControl_i(aluc), .ALUSrcA_i(alu_sa), .ALUSrcB_i(alu_sb), .RegWrite_i(rw), .MemWrite_i(mw),
    .ResultSrc_i(rsrc), .ALUResultM_i(alu_m), .RdM_i(rdm), .RegWriteM_i(rwm), .ResultW_i(res_w),
    .RdW_i(rdw), .RegWriteW_i(rww), .SrcA_o(srca), .SrcB_o(srcb), .ALUControl_o(aluce),
    .WriteData_o(wdata), .PCE_o(pce), .RdE_o(rde), .RegWriteE_o(rwe), .MemWriteE_o(mwe),
    .ResultSrcE_o(rsrce), .ValidE_o(vale), .LoadUse_o(lu)
  );
  // model of what the EX slot currently holds
  typedef struct {
    bit v, sa, sb, rw, mw;
    bit [31:0] a, b, imm, pc;
    bit [4:0] s1, s2, rd;
    bit [2:0] op;
    bit [1:0] rs;
  } slot_t;
  slot_t m, empty;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask
  function automatic bit [31:0] fwd(bit [4:0] s, bit [31:0] dflt);
    if (s == 0) return dflt;
    if (rwm && rdm == s) return alu_m;
    if (rww && rdw == s) return res_w;
    return dflt;
  endfunction
  function automatic bit hazard();
    return m.v && m.rs == 2'd1 && m.rd != 0 && valid && (rs1 == m.rd || rs2 == m.rd);
  endfunction
  task automatic check_all();
    #1;
    chk("srca", srca, m.sa ? m.pc : fwd(m.s1, m.a));
    chk("srcb", srcb, m.sb ? m.imm : fwd(m.s2, m.b));
    chk("wdata", wdata, fwd(m.s2, m.b));
    chk("aluc", 32'(aluce), 32'(m.op));
    chk("pce", pce, m.pc);
    chk("rde", 32'(rde), 32'(m.rd));
    chk("rwe", 32'(rwe), 32'(m.rw));
    chk("mwe", 32'(mwe), 32'(m.mw));
    chk("rsrce", 32'(rsrce), 32'(m.rs));
    chk("vale", 32'(vale), 32'(m.v));
    chk("lu", 32'(lu), 32'(hazard()));
  endtask
  task automatic tick();
    slot_t nxt;
    if (rst || flush) nxt = empty;
    else if (stall) nxt = m;
    else if (hazard() || !valid) nxt = empty;
    else nxt = '{v: 1, sa: alu_sa, sb: alu_sb, rw: rw, mw: mw, a: rd1, b: rd2, imm: imm, pc: pc,
                 s1: rs1, s2: rs2, rd: rd, op: aluc, rs: rsrc};
    @(posedge clk);
    m = nxt;
    @(negedge clk);
  endtask
  task automatic rand_in();
    valid = $urandom_range(0, 3) != 0;
    rd1 = $urandom; rd2 = $urandom; imm = $urandom; pc = $urandom;
    rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
    aluc = 3'($urandom); alu_sa = 1'($urandom); alu_sb = 1'($urandom);
    rw = 1'($urandom); mw = 1'($urandom); rsrc = 2'($urandom);
    alu_m = $urandom; res_w = $urandom;
    rdm = 5'($urandom_range(0, 7)); rdw = 5'($urandom_range(0, 7));
    rwm = 1'($urandom); rww = 1'($urandom);
  endtask
  task automatic instr(bit [31:0] a, bit [31:0] b, bit [4:0] s1, bit [4:0] s2, bit [4:0] d,
                       bit [2:0] op, bit sb, bit [31:0] im, bit [1:0] rs);
    valid = 1; rd1 = a; rd2 = b; rs1 = s1; rs2 = s2; rd = d; aluc = op;
    alu_sa = 0; alu_sb = sb; imm = im; rsrc = rs; rw = 1; mw = 0; pc = 32'h40;
    rwm = 0; rww = 0; stall = 0; flush = 0;
  endtask
  initial begin
    empty = '{default: 0};
    m = empty;
    stall = 0; flush = 0;
    rand_in();
    rst = 1;
    @(negedge clk);
    tick();
    check_all();
    chk("rst_vale", 32'(vale), 0);
    chk("rst_lu", 32'(lu), 0);
    rst = 0; valid = 0;
    tick();
    check_all();
    chk("bubble_rwe", 32'(rwe), 0);
    instr(5, 7, 3, 4, 9, 3'b001, 0, 0, 2'b00);
    tick();
    check_all();
    chk("cap_srca", srca, 5);
    chk("cap_srcb", srcb, 7);
    chk("cap_aluc", 32'(aluce), 1);
    rdm = 3; rwm = 1; alu_m = 32'h100;
    check_all();
    chk("fwd_mem_a", srca, 32'h100);
    instr(32'h55, 32'h66, 0, 4, 9, 3'b010, 0, 0, 2'b00);
    tick();
    rdm = 4; rdw = 4; rwm = 1; rww = 1; alu_m = 32'hAA; res_w = 32'hBB;
    check_all();
    chk("mem_over_wb", srcb, 32'hAA);
    rdm = 0; rdw = 0;
    check_all();
    chk("x0_nofwd", srca, 32'h55);
    instr(1, 2, 1, 2, 6, 3'b000, 1, 4, 2'b01);
    tick();
    rs1 = 1; rs2 = 6; rd = 7; rsrc = 0;
    check_all();
    chk("lu_set", 32'(lu), 1);
    tick();
    check_all();
    chk("lu_bubble", 32'(vale), 0);
    chk("lu_drop", 32'(lu), 0);
    instr(3, 4, 1, 2, 8, 3'b101, 0, 0, 2'b00);
    pc = 32'h80;
    tick();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      pc = 32'h1000 + i; rd = 5'(i + 1);
      tick();
      check_all();
      chk("stall_pce", pce, 32'h80);
      chk("stall_vale", 32'(vale), 1);
    end
    flush = 1;
    tick();
    check_all();
    chk("flush_vale", 32'(vale), 0);
    instr(0, 32'h99, 1, 5, 0, 3'b000, 1, 8, 2'b00);
    mw = 1; rw = 0;
    tick();
    rdw = 5; rww = 1; res_w = 32'h1234;
    check_all();
    chk("st_srcb", srcb, 8);
    chk("st_wdata", wdata, 32'h1234);
    chk("st_mwe", 32'(mwe), 1);
    for (int i = 0; i < 400; i++) begin
      rand_in();
      stall = $urandom_range(0, 5) == 0;
      flush = $urandom_range(0, 11) == 0;
      rst = $urandom_range(0, 49) == 0;
      check_all();
      tick();
    end
    rst = 0; stall = 0; flush = 0;
    check_all();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
